// File: rtl/photonic_tx_serializer.sv
// Serializes 32-bit packets into 41-bit optical frames (preamble, payload, even parity).
// Holds at most one request in a queue while a frame is in flight, honours link backpressure,
// and sets a sticky flag when a request is dropped.
module photonic_tx_serializer #(
  parameter logic [7:0] PREAMBLE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_tx_flag,
  input  logic [31:0] data_tx_packet,
  input  logic        link_ready,
  output logic        link_tx,
  output logic        link_tx_valid,
  output logic        data_tx_complete_flag,
  output logic        tx_busy,
  output logic        tx_pending,
  output logic        tx_overflow
);

  localparam int unsigned PKT_W   = 32;
  localparam int unsigned PRE_W   = 8;
  localparam int unsigned FRAME_W = PRE_W + PKT_W + 1;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PARITY
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [PKT_W-1:0]     hold_q, hold_d;
  logic                 pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic                 complete_q, complete_d;
  logic                 busy_q, busy_d;
  logic                 accept;
  logic                 last_bit;

  // Whole frame is built at latch time, so parity always reflects the latched packet.
  function automatic logic [FRAME_W-1:0] frame_of(input logic [PKT_W-1:0] pkt);
    return {PREAMBLE, pkt, ^pkt};
  endfunction

  // The bit on the wire is always the top of the shift register.
  assign link_tx               = shift_q[FRAME_W-1];
  assign link_tx_valid         = busy_q;
  assign tx_busy               = busy_q;
  assign tx_pending            = pending_q;
  assign tx_overflow           = overflow_q;
  assign data_tx_complete_flag = complete_q;

  assign accept   = busy_q & link_ready;
  assign last_bit = accept & (state_q == ST_PARITY);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, bit sequencing and request queueing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    complete_d = 1'b0;

    if (accept) begin
      shift_d = {shift_q[FRAME_W-2:0], 1'b0};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (data_tx_flag) begin
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
          shift_d = frame_of(data_tx_packet);
        end
      end
      ST_PREAMBLE: begin
        if (accept) begin
          if (cnt_q == CNT_W'(PRE_W - 1)) begin
            state_d = ST_PAYLOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (cnt_q == CNT_W'(PKT_W - 1)) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (accept) begin
          complete_d = 1'b1;
          cnt_d      = '0;
          if (pending_q) begin
            state_d   = ST_PREAMBLE;
            shift_d   = frame_of(hold_q);
            hold_d    = '0;
            pending_d = 1'b0;
          end else if (data_tx_flag) begin
            state_d = ST_PREAMBLE;
            shift_d = frame_of(data_tx_packet);
          end else begin
            state_d = ST_IDLE;
            shift_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase

    // A request arriving mid-frame goes to the holding slot, or is dropped if it is taken.
    // On the completion edge a queued packet wins, so a simultaneous request is dropped.
    if (busy_q && data_tx_flag) begin
      if (last_bit) begin
        if (pending_q) begin
          overflow_d = 1'b1;
        end
      end else if (!pending_q) begin
        hold_d    = data_tx_packet;
        pending_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Valid/busy follow the next state so both are registered.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_photonic_tx_serializer.sv
// Self-checking bench: random packets and stalls compared against a frame-level reference model.
module tb_photonic_tx_serializer;

  localparam logic [7:0] PRE = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_tx_flag = 1'b0;
  logic [31:0] data_tx_packet = '0;
  logic        link_ready = 1'b0;
  logic        link_tx;
  logic        link_tx_valid;
  logic        data_tx_complete_flag;
  logic        tx_busy;
  logic        tx_pending;
  logic        tx_overflow;

  int n_run  = 0;
  int n_fail = 0;

  photonic_tx_serializer #(.PREAMBLE(PRE)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_tx_flag          (data_tx_flag),
    .data_tx_packet        (data_tx_packet),
    .link_ready            (link_ready),
    .link_tx               (link_tx),
    .link_tx_valid         (link_tx_valid),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_busy               (tx_busy),
    .tx_pending            (tx_pending),
    .tx_overflow           (tx_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference frame in transmit order: preamble, payload, then XOR of payload bits.
  function automatic logic [40:0] model_frame(input logic [31:0] p);
    logic par;
    par = 1'b0;
    for (int i = 0; i < 32; i++) par = par ^ p[i];
    return {PRE, p, par};
  endfunction

  // Present a request at the current negedge; it is sampled at the next rising edge.
  task automatic start(input logic [31:0] p);
    data_tx_packet = p;
    data_tx_flag   = 1'b1;
    link_ready     = 1'b1;
  endtask

  // Drive the link for one or two frames, collecting accepted bits and completion cycles.
  // Cycle k is the k-th negedge after the request was presented.
  task automatic run(input int nframes, input int stall_at, input int stall_len,
                     input int inj1, input logic [31:0] p1,
                     input int inj2, input logic [31:0] p2,
                     output logic [81:0] vec, output int got,
                     output int c0, output int c1, output int stall_bad,
                     output logic pend_mid, output bit timeout);
    int   cyc;
    int   comps;
    int   stall_left;
    bit   stall_done;
    logic held;
    cyc = 0; comps = 0; stall_left = 0; stall_done = 1'b0; held = 1'b0;
    vec = '0; got = 0; c0 = -1; c1 = -1; stall_bad = 0; pend_mid = 1'b0; timeout = 1'b0;
    while (comps < nframes) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin
        timeout = 1'b1;
        break;
      end
      data_tx_flag = 1'b0;
      if (cyc == inj1) begin data_tx_flag = 1'b1; data_tx_packet = p1; end
      if (cyc == inj2) begin data_tx_flag = 1'b1; data_tx_packet = p2; end
      if (cyc == 10) pend_mid = tx_pending;
      if (data_tx_complete_flag === 1'b1) begin
        if (comps == 0) c0 = cyc; else c1 = cyc;
        comps++;
      end
      if (comps == nframes) break;
      if (!stall_done && stall_len > 0 && got == stall_at) begin
        stall_left = stall_len;
        held       = link_tx;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        link_ready = 1'b0;
        stall_left--;
        if (link_tx !== held || link_tx_valid !== 1'b1) stall_bad++;
      end else begin
        link_ready = 1'b1;
      end
      if (link_tx_valid === 1'b1 && link_ready) begin
        vec = {vec[80:0], link_tx};
        got++;
      end
    end
    data_tx_flag = 1'b0;
    link_ready   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_run++; if (link_tx !== 1'b0) begin n_fail++; $display("FAIL reset_link_tx: got %b want 0", link_tx); end
    n_run++; if (link_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", link_tx_valid); end
    n_run++; if (data_tx_complete_flag !== 1'b0) begin n_fail++; $display("FAIL reset_complete: got %b want 0", data_tx_complete_flag); end
    n_run++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_run++; if (tx_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", tx_pending); end
    n_run++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", tx_overflow); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_run++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b want 0", tx_busy); end
  endtask

  task automatic test_single();
    logic [81:0] vec; int got, c0, c1, sb; logic pm; bit to;
    logic [40:0] exp_f;
    exp_f = model_frame(32'hDEADBEEF);
    start(32'hDEADBEEF);
    run(1, -1, 0, -1, '0, -1, '0, vec, got, c0, c1, sb, pm, to);
    n_run++; if (to) begin n_fail++; $display("FAIL single_timeout: no completion within budget"); end
    n_run++; if (vec[40:0] !== exp_f) begin n_fail++; $display("FAIL single_frame: got %h want %h", vec[40:0], exp_f); end
    n_run++; if (got != 41) begin n_fail++; $display("FAIL single_bits: got %0d want 41", got); end
    n_run++; if (vec[0] !== 1'b0) begin n_fail++; $display("FAIL single_parity: got %b want 0", vec[0]); end
    n_run++; if (c0 != 42) begin n_fail++; $display("FAIL single_complete_cycle: got %0d want 42", c0); end
    @(negedge clk);
    n_run++; if (data_tx_complete_flag !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b want 0", data_tx_complete_flag); end
    n_run++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", tx_busy); end
    n_run++; if ({link_tx_valid, link_tx} !== 2'b00) begin n_fail++; $display("FAIL single_idle_outputs: got %b want 00", {link_tx_valid, link_tx}); end
  endtask

  task automatic test_parity();
    logic [81:0] vec; int got, c0, c1, sb; logic pm; bit to;
    logic [31:0] pk [2];
    logic        want [2];
    pk[0] = 32'h00000001; want[0] = 1'b1;
    pk[1] = 32'h00000000; want[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start(pk[i]);
      run(1, -1, 0, -1, '0, -1, '0, vec, got, c0, c1, sb, pm, to);
      n_run++; if (to || vec[0] !== want[i]) begin n_fail++; $display("FAIL parity_%0d: got %b want %b", i, vec[0], want[i]); end
      n_run++; if (vec[40:0] !== model_frame(pk[i])) begin n_fail++; $display("FAIL parity_frame_%0d: got %h want %h", i, vec[40:0], model_frame(pk[i])); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [81:0] vec; int got, c0, c1, sb; logic pm; bit to;
    logic [31:0] p;
    p = $urandom;
    start(p);
    run(1, 18, 5, -1, '0, -1, '0, vec, got, c0, c1, sb, pm, to);
    n_run++; if (to) begin n_fail++; $display("FAIL bp_timeout: no completion within budget"); end
    n_run++; if (sb != 0) begin n_fail++; $display("FAIL bp_hold: %0d stall cycles changed output, want 0", sb); end
    n_run++; if (vec[40:0] !== model_frame(p)) begin n_fail++; $display("FAIL bp_frame: got %h want %h", vec[40:0], model_frame(p)); end
    n_run++; if (c0 != 47) begin n_fail++; $display("FAIL bp_complete_cycle: got %0d want 47", c0); end
    @(negedge clk);
  endtask

  task automatic test_queueing();
    logic [81:0] vec; int got, c0, c1, sb; logic pm; bit to;
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    start(a);
    run(2, -1, 0, 5, b, 6, c, vec, got, c0, c1, sb, pm, to);
    n_run++; if (to) begin n_fail++; $display("FAIL queue_timeout: frames did not complete"); end
    n_run++; if (pm !== 1'b1) begin n_fail++; $display("FAIL queue_pending: got %b want 1", pm); end
    n_run++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL queue_overflow: got %b want 1", tx_overflow); end
    n_run++; if (vec !== {model_frame(a), model_frame(b)}) begin n_fail++; $display("FAIL queue_stream: got %h want %h", vec, {model_frame(a), model_frame(b)}); end
    n_run++; if (c0 != 42 || c1 != 83) begin n_fail++; $display("FAIL queue_b2b: completions at %0d,%0d want 42,83", c0, c1); end
    n_run++; if (tx_pending !== 1'b0) begin n_fail++; $display("FAIL queue_pending_clear: got %b want 0", tx_pending); end
    @(negedge clk);
    n_run++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL queue_idle: busy %b want 0", tx_busy); end
  endtask

  task automatic test_random();
    logic [81:0] vec; int got, c0, c1, sb; logic pm; bit to;
    logic [31:0] p;
    int at, len;
    for (int i = 0; i < 6; i++) begin
      p   = $urandom;
      at  = int'($urandom_range(0, 40));
      len = int'($urandom_range(1, 4));
      start(p);
      run(1, at, len, -1, '0, -1, '0, vec, got, c0, c1, sb, pm, to);
      n_run++; if (to || vec[40:0] !== model_frame(p) || sb != 0) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h (stall at %0d len %0d, hold errs %0d)", i, vec[40:0], model_frame(p), at, len, sb);
      end
      n_run++; if (c0 != 42 + len) begin n_fail++; $display("FAIL random_latency_%0d: got %0d want %0d", i, c0, 42 + len); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [81:0] vec; int got, c0, c1, sb; logic pm; bit to;
    logic [31:0] p, p2;
    int  cnt, comp_seen;
    bit  hit;
    p = $urandom; p2 = $urandom;
    cnt = 0; hit = 1'b0; comp_seen = 0;
    start(p);
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      data_tx_flag = 1'b0;
      if (cnt == 28) hit = 1'b1;
      else if (link_tx_valid === 1'b1) cnt++;
    end
    n_run++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach: accepted %0d bits want 28", cnt); end
    // Assert reset between clock edges; outputs must clear without a clock.
    #2 rst = 1'b0;
    #1;
    n_run++; if ({link_tx, link_tx_valid, data_tx_complete_flag, tx_busy, tx_pending, tx_overflow} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_async: outputs %b want 000000", {link_tx, link_tx_valid, data_tx_complete_flag, tx_busy, tx_pending, tx_overflow});
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (data_tx_complete_flag !== 1'b0) comp_seen++;
    end
    n_run++; if (comp_seen != 0) begin n_fail++; $display("FAIL rstmid_no_complete: %0d pulses want 0", comp_seen); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start(p2);
    run(1, -1, 0, -1, '0, -1, '0, vec, got, c0, c1, sb, pm, to);
    n_run++; if (to || vec[40:0] !== model_frame(p2)) begin n_fail++; $display("FAIL rstmid_fresh: got %h want %h", vec[40:0], model_frame(p2)); end
    n_run++; if (got != 41 || c0 != 42) begin n_fail++; $display("FAIL rstmid_fresh_len: bits %0d cycle %0d want 41,42", got, c0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_backpressure();
    test_queueing();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
